// File: rtl/i2c_master_byte_ctrl.sv
// Byte-level I2C master sequencer. It turns START/WRITE/READ/STOP commands into
// bit-level commands for a separate bit controller and assembles or serializes the byte.
module i2c_master_byte_ctrl (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       i2c_en_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       read_i,
  input  logic       write_i,
  input  logic       tx_ack_i,
  input  logic [7:0] tx_data_i,
  output logic [7:0] rx_data_o,
  output logic       rx_ack_o,
  output logic       i2c_done_o,
  output logic       i2c_al_o,
  output logic [2:0] bit_cmd_o,
  output logic       bit_din_o,
  input  logic       bit_ack_i,
  input  logic       bit_dout_i,
  input  logic       bit_al_i
);

  // states: IDLE wait for command | START start cond | WRITE tx bit | READ rx bit | ACK ack bit | STOP stop cond
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_ACK   = 3'd4;
  localparam logic [2:0] ST_STOP  = 3'd5;

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_START = 3'd1;
  localparam logic [2:0] CMD_STOP  = 3'd2;
  localparam logic [2:0] CMD_WRITE = 3'd3;
  localparam logic [2:0] CMD_READ  = 3'd4;

  logic [2:0] state_q, state_d;
  logic [2:0] cmd_q, cmd_d;
  logic       din_q, din_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_ack_q, rx_ack_d;
  logic       done_q, done_d;
  logic       al_q;
  logic       any_cmd;
  logic [7:0] sr_rd;

  assign any_cmd = start_i | stop_i | read_i | write_i;
  assign sr_rd   = {sr_q[6:0], bit_dout_i};

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    din_d     = din_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    rx_data_d = rx_data_q;
    rx_ack_d  = rx_ack_q;
    done_d    = 1'b0;

    if (bit_al_i || !i2c_en_i) begin
      state_d = ST_IDLE;
      cmd_d   = CMD_NOP;
      din_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // done_q blocks re-accepting commands still held high during the done pulse
          if (!done_q && any_cmd) begin
            if (start_i) begin
              state_d = ST_START; cmd_d = CMD_START; din_d = 1'b0;
            end else if (read_i) begin
              state_d = ST_READ; cmd_d = CMD_READ; din_d = 1'b0; cnt_d = 3'd7;
            end else if (write_i) begin
              state_d = ST_WRITE; cmd_d = CMD_WRITE; sr_d = tx_data_i;
              cnt_d = 3'd7; din_d = tx_data_i[7];
            end else begin
              state_d = ST_STOP; cmd_d = CMD_STOP; din_d = 1'b0;
            end
          end
        end
        ST_START: if (bit_ack_i) begin
          if (read_i) begin
            state_d = ST_READ; cmd_d = CMD_READ; din_d = 1'b0; cnt_d = 3'd7;
          end else if (write_i) begin
            state_d = ST_WRITE; cmd_d = CMD_WRITE; sr_d = tx_data_i;
            cnt_d = 3'd7; din_d = tx_data_i[7];
          end else if (stop_i) begin
            state_d = ST_STOP; cmd_d = CMD_STOP; din_d = 1'b0;
          end else begin
            state_d = ST_IDLE; cmd_d = CMD_NOP; din_d = 1'b0; done_d = 1'b1;
          end
        end
        ST_WRITE: if (bit_ack_i) begin
          if (cnt_q == 3'd0) begin
            state_d = ST_ACK; cmd_d = CMD_READ; din_d = 1'b0;
          end else begin
            sr_d  = {sr_q[6:0], 1'b0};
            cnt_d = cnt_q - 3'd1;
            din_d = sr_q[6];
          end
        end
        ST_READ: if (bit_ack_i) begin
          sr_d = sr_rd;
          if (cnt_q == 3'd0) begin
            rx_data_d = sr_rd;
            state_d   = ST_ACK; cmd_d = CMD_WRITE; din_d = tx_ack_i;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        ST_ACK: if (bit_ack_i) begin
          rx_ack_d = bit_dout_i;
          if (stop_i) begin
            state_d = ST_STOP; cmd_d = CMD_STOP; din_d = 1'b0;
          end else begin
            state_d = ST_IDLE; cmd_d = CMD_NOP; din_d = 1'b0; done_d = 1'b1;
          end
        end
        ST_STOP: if (bit_ack_i) begin
          state_d = ST_IDLE; cmd_d = CMD_NOP; din_d = 1'b0; done_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE; cmd_d = CMD_NOP; din_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      cmd_q     <= CMD_NOP;
      din_q     <= 1'b0;
      sr_q      <= 8'h00;
      cnt_q     <= 3'd0;
      rx_data_q <= 8'h00;
      rx_ack_q  <= 1'b0;
      done_q    <= 1'b0;
      al_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      din_q     <= din_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      rx_data_q <= rx_data_d;
      rx_ack_q  <= rx_ack_d;
      done_q    <= done_d;
      al_q      <= bit_al_i;
    end
  end

  assign rx_data_o  = rx_data_q;
  assign rx_ack_o   = rx_ack_q;
  assign i2c_done_o = done_q;
  assign i2c_al_o   = al_q;
  assign bit_cmd_o  = cmd_q;
  assign bit_din_o  = din_q;

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Scoreboard bench for i2c_master_byte_ctrl: a bit-controller model acks every 4 cycles,
// a monitor checks each acked bit command and each done pulse against queued expectations.
module tb_i2c_master_byte_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i2c_en = 1'b0;
  logic       start = 1'b0, stop = 1'b0, read = 1'b0, write = 1'b0;
  logic       tx_ack = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_ack, done, al;
  logic [2:0] bit_cmd;
  logic       bit_din;
  logic       bit_ack = 1'b0, bit_dout = 1'b0, bit_al = 1'b0;

  typedef struct { logic [2:0] cmd; logic din; } bit_exp_t;
  typedef struct { logic [7:0] rx; logic ack; } done_exp_t;

  bit_exp_t  exp_bits[$];
  done_exp_t exp_done[$];
  logic      dout_q[$];
  int        ack_seen = 0;
  int        pass_cnt = 0;
  int        total_cnt = 0;

  i2c_master_byte_ctrl dut (
    .clk_i(clk), .rst_n_i(rst_n), .i2c_en_i(i2c_en),
    .start_i(start), .stop_i(stop), .read_i(read), .write_i(write),
    .tx_ack_i(tx_ack), .tx_data_i(tx_data),
    .rx_data_o(rx_data), .rx_ack_o(rx_ack), .i2c_done_o(done), .i2c_al_o(al),
    .bit_cmd_o(bit_cmd), .bit_din_o(bit_din),
    .bit_ack_i(bit_ack), .bit_dout_i(bit_dout), .bit_al_i(bit_al)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_bit(input logic [2:0] cmd, input logic din);
    bit_exp_t e;
    e.cmd = cmd; e.din = din;
    exp_bits.push_back(e);
  endtask

  task automatic push_done(input logic [7:0] rx, input logic ack);
    done_exp_t e;
    e.rx = rx; e.ack = ack;
    exp_done.push_back(e);
  endtask

  task automatic push_byte_dout(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) dout_q.push_back(b[i]);
  endtask

  task automatic wait_acks(input int n, input string name);
    int base;
    base = ack_seen;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ack_seen >= base + n) return;
    end
    total_cnt++;
    $display("FAIL %s: timeout, got %0d acks expected %0d", name, ack_seen - base, n);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) return;
    end
    total_cnt++;
    $display("FAIL %s: timeout, got no done pulse expected one", name);
  endtask

  // Bit-controller model: every active command is acked on its 4th cycle.
  initial begin
    int mcnt;
    mcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      bit_ack = 1'b0;
      if (!rst_n || bit_cmd == 3'd0) mcnt = 0;
      else begin
        mcnt++;
        if (mcnt == 4) begin
          mcnt = 0;
          bit_ack = 1'b1;
          bit_dout = (dout_q.size() > 0) ? dout_q.pop_front() : 1'b0;
          ack_seen++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bit_ack) begin
          if (exp_bits.size() == 0) begin
            total_cnt++;
            $display("FAIL extra_ack: got cmd %0d expected no ack", bit_cmd);
          end else begin
            bit_exp_t e;
            e = exp_bits.pop_front();
            check("bit_cmd", 32'(bit_cmd), 32'(e.cmd));
            if (e.cmd == 3'd3) check("bit_din", 32'(bit_din), 32'(e.din));
          end
        end
        if (done) begin
          check("bits_before_done", exp_bits.size(), 0);
          if (exp_done.size() == 0) begin
            total_cnt++;
            $display("FAIL extra_done: got done pulse expected none");
          end else begin
            done_exp_t d;
            d = exp_done.pop_front();
            check("rx_data", 32'(rx_data), 32'(d.rx));
            check("rx_ack", 32'(rx_ack), 32'(d.ack));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] a5;
    a5 = 8'hA5;
    repeat (3) @(negedge clk);
    check("rst_cmd", 32'(bit_cmd), 0);
    check("rst_din", 32'(bit_din), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_rx_ack", 32'(rx_ack), 0);
    check("rst_done", 32'(done), 0);
    check("rst_al", 32'(al), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    i2c_en = 1'b1;

    // Start+Write of A5, ACK phase reads 0
    push_bit(3'd1, 1'b0);
    for (int i = 7; i >= 0; i--) push_bit(3'd3, a5[i]);
    push_bit(3'd4, 1'b0);
    push_done(8'h00, 1'b0);
    tx_data = 8'hA5; start = 1'b1; write = 1'b1;
    wait_done("s1_done");
    check("s1_nop_in_done", 32'(bit_cmd), 0);
    @(posedge clk); #1;
    start = 1'b0; write = 1'b0;
    @(negedge clk);
    check("s1_no_restart", 32'(bit_cmd), 0);
    check("s1_done_one_cycle", 32'(done), 0);

    // Read with NACK: stream 0110_1001
    for (int i = 0; i < 8; i++) push_bit(3'd4, 1'b0);
    push_bit(3'd3, 1'b1);
    push_done(8'h69, 1'b0);
    push_byte_dout(8'h69);
    dout_q.push_back(1'b0);
    @(posedge clk); #1;
    tx_ack = 1'b1; read = 1'b1;
    wait_done("s2_done");
    @(posedge clk); #1;
    read = 1'b0; tx_ack = 1'b0;

    // Write+Stop of 00, slave NACKs
    for (int i = 0; i < 8; i++) push_bit(3'd3, 1'b0);
    push_bit(3'd4, 1'b0);
    push_bit(3'd2, 1'b0);
    push_done(8'h69, 1'b1);
    push_byte_dout(8'h00);
    dout_q.push_back(1'b1);
    @(posedge clk); #1;
    tx_data = 8'h00; write = 1'b1; stop = 1'b1;
    wait_done("s3_done");
    @(posedge clk); #1;
    write = 1'b0; stop = 1'b0;

    // Arbitration lost during the 3rd write bit
    push_bit(3'd1, 1'b0);
    push_bit(3'd3, 1'b1);
    push_bit(3'd3, 1'b0);
    @(posedge clk); #1;
    tx_data = 8'hA5; start = 1'b1; write = 1'b1;
    wait_acks(3, "s4_acks");
    @(posedge clk); #1;
    check("s4_cmd_before_al", 32'(bit_cmd), 3);
    bit_al = 1'b1;
    @(posedge clk); #1;
    check("s4_abort_cmd", 32'(bit_cmd), 0);
    check("s4_al_high", 32'(al), 1);
    check("s4_no_done", 32'(done), 0);
    bit_al = 1'b0; start = 1'b0; write = 1'b0;
    @(posedge clk); #1;
    check("s4_al_low", 32'(al), 0);
    check("s4_idle_cmd", 32'(bit_cmd), 0);
    check("s4_rx_data_kept", 32'(rx_data), 32'h69);
    check("s4_rx_ack_kept", 32'(rx_ack), 1);
    check("s4_bits_left", exp_bits.size(), 0);

    // Disabled core ignores commands
    i2c_en = 1'b0; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("s5_disabled_cmd", 32'(bit_cmd), 0);
    end
    @(posedge clk); #1;
    start = 1'b0; i2c_en = 1'b1;

    // Reset in the middle of a read
    push_bit(3'd4, 1'b0);
    push_bit(3'd4, 1'b0);
    @(posedge clk); #1;
    read = 1'b1;
    wait_acks(2, "s6_acks");
    @(posedge clk); #3;
    check("s6_cmd_before_rst", 32'(bit_cmd), 4);
    rst_n = 1'b0;
    #1;
    check("s6_rst_cmd", 32'(bit_cmd), 0);
    check("s6_rst_din", 32'(bit_din), 0);
    check("s6_rst_rx_data", 32'(rx_data), 0);
    check("s6_rst_rx_ack", 32'(rx_ack), 0);
    check("s6_rst_done", 32'(done), 0);
    check("s6_rst_al", 32'(al), 0);
    read = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("s6_idle_after_rst", 32'(bit_cmd), 0);
    check("s6_bits_left", exp_bits.size(), 0);
    check("final_done_left", exp_done.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
